// File: rtl/seqver_pkg.sv
// Shared types and helpers for the parametrised sequence verifier.
// Holds the FSM state enum, result codes and the width helper.
package seqver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    PASS,
    FAIL,
    TIMEOUT
  } state_t;

  typedef enum logic [1:0] {
    RES_PEND    = 2'b00,
    RES_PASS    = 2'b01,
    RES_FAIL    = 2'b10,
    RES_TIMEOUT = 2'b11
  } result_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_digit_mux.sv
// Selects key digit idx from the latched key, digit 0 being the MS digit.
// Ports: key (packed key), idx (digit index), digit (selected digit).
module seq_digit_mux
  import seqver_pkg::*;
#(
  parameter int SEQ_LEN = 4,
  parameter int DIGIT_W = 4
) (
  input  logic [SEQ_LEN*DIGIT_W-1:0]    key,
  input  logic [clog2w(SEQ_LEN)-1:0]    idx,
  output logic [DIGIT_W-1:0]            digit
);

  localparam int IW = clog2w(SEQ_LEN);

  always_comb begin
    digit = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (idx == IW'(i))
        digit = key[(SEQ_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

endmodule

// File: rtl/sequence_verifier_n.sv
// Puzzle sequence verifier: latches a key, checks entered digits in order,
// reports pass/fail/timeout with a retry budget and a saturating level.
// Ports: clk, rst (sync, active-high), game_active, key_in, key_load,
//   digit_in, verify, timeout -> result, digit_idx, tries_left, level, retry.
module sequence_verifier_n
  import seqver_pkg::*;
#(
  parameter int SEQ_LEN    = 4,
  parameter int DIGIT_W    = 4,
  parameter int MAX_TRIES  = 3,
  parameter int NUM_LEVELS = 8,
  parameter int EARLY_FAIL = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          game_active,
  input  logic [SEQ_LEN*DIGIT_W-1:0]    key_in,
  input  logic                          key_load,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic                          verify,
  input  logic                          timeout,
  output logic [1:0]                    result,
  output logic [clog2w(SEQ_LEN)-1:0]    digit_idx,
  output logic [3:0]                    tries_left,
  output logic [clog2w(NUM_LEVELS)-1:0] level,
  output logic                          retry
);

  localparam int IW = clog2w(SEQ_LEN);
  localparam int LW = clog2w(NUM_LEVELS);
  localparam int KW = SEQ_LEN * DIGIT_W;

  state_t          state_q, state_d;
  result_t         res_q, res_d;
  logic [KW-1:0]   key_q, key_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      tries_q, tries_d;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic            mis_q, mis_d;
  logic            retry_q, retry_d;

  logic [DIGIT_W-1:0] cur_digit;
  logic               wrong;
  logic               mis_nx;
  logic               last;
  logic               att_end;

  seq_digit_mux #(
    .SEQ_LEN (SEQ_LEN),
    .DIGIT_W (DIGIT_W)
  ) u_mux (
    .key   (key_q),
    .idx   (idx_q),
    .digit (cur_digit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= RES_PEND;
      key_q   <= '0;
      idx_q   <= '0;
      tries_q <= '0;
      lvl_q   <= '0;
      mis_q   <= 1'b0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      tries_q <= tries_d;
      lvl_q   <= lvl_d;
      mis_q   <= mis_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    wrong   = (digit_in != cur_digit);
    mis_nx  = mis_q | wrong;
    last    = (idx_q == IW'(SEQ_LEN-1));
    // An attempt ends at the last digit, or at the first wrong
    // digit when early fail is enabled.
    att_end = last | ((EARLY_FAIL != 0) & wrong);

    state_d = state_q;
    res_d   = res_q;
    key_d   = key_q;
    idx_d   = idx_q;
    tries_d = tries_q;
    lvl_d   = lvl_q;
    mis_d   = mis_q;
    retry_d = 1'b0;

    if (!game_active) begin
      state_d = IDLE;
      res_d   = RES_PEND;
      idx_d   = '0;
      tries_d = '0;
      mis_d   = 1'b0;
    end else if (key_load) begin
      state_d = ENTRY;
      res_d   = RES_PEND;
      key_d   = key_in;
      idx_d   = '0;
      tries_d = 4'(MAX_TRIES);
      mis_d   = 1'b0;
    end else if (state_q == ENTRY) begin
      if (timeout) begin
        state_d = TIMEOUT;
        res_d   = RES_TIMEOUT;
      end else if (verify) begin
        if (!att_end) begin
          idx_d = idx_q + IW'(1);
          mis_d = mis_nx;
        end else if (!mis_nx) begin
          state_d = PASS;
          res_d   = RES_PASS;
          if (lvl_q != LW'(NUM_LEVELS-1))
            lvl_d = lvl_q + LW'(1);
        end else if (tries_q > 4'd1) begin
          tries_d = tries_q - 4'd1;
          idx_d   = '0;
          mis_d   = 1'b0;
          retry_d = 1'b1;
        end else begin
          state_d = FAIL;
          res_d   = RES_FAIL;
          tries_d = '0;
        end
      end
    end
  end

  assign result     = res_q;
  assign digit_idx  = idx_q;
  assign tries_left = tries_q;
  assign level      = lvl_q;
  assign retry      = retry_q;

endmodule
